// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the data-port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;
  typedef enum logic {GNT_C = 1'b0, GNT_U = 1'b1} grant_t;
  localparam logic [3:0] BURST_1W = 4'b0000;
  localparam logic [3:0] BURST_16W = 4'b1111;
  localparam int LINE_W = 512;
  localparam int STRB_W = 64;
  localparam int GAP_W = 2;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: 2-way picker, uncached-first or round-robin when ARB_RR_EN is defined
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef ARB_RR_EN
  input  grant_t     rr_last,
`endif
  output grant_t     grant
);
  always_comb
`ifdef ARB_RR_EN
    grant = req == 2'b11 ? (rr_last == GNT_U ? GNT_C : GNT_U) : req == 2'b01 ? GNT_C : GNT_U;
`else
    grant = req == 2'b01 ? GNT_C : GNT_U;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the bridge data port between cached and uncached requesters (ARB_RR_EN selects round-robin)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              c_req,
  input  logic              u_req,
  input  logic [3:0]        c_burst,
  input  logic [3:0]        u_burst,
  input  logic              c_wr,
  input  logic              u_wr,
  input  logic [STRB_W-1:0] c_strb,
  input  logic [STRB_W-1:0] u_strb,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       u_addr,
  input  logic [LINE_W-1:0] c_wdata,
  input  logic [LINE_W-1:0] u_wdata,
  output logic [LINE_W-1:0] c_rdata,
  output logic [LINE_W-1:0] u_rdata,
  output logic              c_addr_ok,
  output logic              u_addr_ok,
  output logic              c_data_ok,
  output logic              u_data_ok,
  output logic              m_req,
  output logic [3:0]        m_burst,
  output logic              m_wr,
  output logic [STRB_W-1:0] m_strb,
  output logic [31:0]       m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  output logic              busy
);
  localparam logic [GAP_W-1:0] GAP = GAP_W'(IDLE_GAP);
  state_t state, state_nx;
  grant_t grant, grant_nx, pick;
  logic [GAP_W-1:0] gap, gap_nx;
  logic armed, armed_nx, gu, g_req, act, done, issue;
  logic [LINE_W-1:0] c_rd_q, u_rd_q;
`ifdef ARB_RR_EN
  grant_t rr_last;
  mem_arb_pick u_pick (.req({u_req, c_req}), .rr_last(rr_last), .grant(pick));
`else
  mem_arb_pick u_pick (.req({u_req, c_req}), .grant(pick));
`endif
  always_comb begin
    gu = grant == GNT_U;
    g_req = gu ? u_req : c_req;
    act = state != IDLE;
    issue = state == IDLE && gap == GAP && (c_req || u_req);
    // first WAIT cycle ignores m_data_ok: it may still be the previous transaction's level
    done = state == WAIT && armed && m_data_ok;
    m_req = state == ADDR && g_req;
    m_burst = !act ? '0 : gu ? u_burst : c_burst;
    m_wr = act && (gu ? u_wr : c_wr);
    m_strb = !act ? '0 : gu ? u_strb : c_strb;
    m_addr = !act ? '0 : gu ? u_addr : c_addr;
    m_wdata = !act ? '0 : gu ? u_wdata : c_wdata;
    c_addr_ok = m_req && m_addr_ok && !gu;
    u_addr_ok = m_req && m_addr_ok && gu;
    c_data_ok = done && !gu;
    u_data_ok = done && gu;
    c_rdata = c_data_ok ? m_rdata : c_rd_q;
    u_rdata = u_data_ok ? m_rdata : u_rd_q;
    busy = act;
  end
  always_comb begin
    state_nx = state;
    gap_nx = gap;
    grant_nx = grant;
    armed_nx = armed;
    case (state)
      IDLE: begin
        if (gap != GAP) gap_nx = gap + 1'b1;
        else if (issue) begin
          grant_nx = pick;
          state_nx = ADDR;
        end
      end
      ADDR: begin
        if (!g_req) begin
          state_nx = IDLE;
          gap_nx = '0;
        end else if (m_addr_ok) begin
          state_nx = WAIT;
          armed_nx = 1'b0;
        end
      end
      default: begin
        armed_nx = 1'b1;
        if (done) begin
          state_nx = IDLE;
          gap_nx = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      gap <= '0;
      grant <= GNT_C;
      armed <= 1'b0;
      c_rd_q <= '0;
      u_rd_q <= '0;
    end else begin
      state <= state_nx;
      gap <= gap_nx;
      grant <= grant_nx;
      armed <= armed_nx;
      if (c_data_ok) c_rd_q <= m_rdata;
      if (u_data_ok) u_rd_q <= m_rdata;
    end
  end
`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_last <= GNT_C;
    else if (issue) rr_last <= pick;
  end
`endif
endmodule
